alu_reg: RTL and testbench

//   Registered N-bit integer ALU for the datapath: AND, OR, ADD, SUB, SLT and
//   AND/OR with inverted B, selected by a 3-bit function code.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_addsub.sv | 31 +++
 rtl/alu_reg.sv | 100 ++++++++++
 tb/tb_alu_reg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Function codes shared by the registered ALU and its adder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] F_AND   = 3'b000;
    localparam logic [2:0] F_OR    = 3'b001;
    localparam logic [2:0] F_ADD   = 3'b010;
    localparam logic [2:0] F_AND_N = 3'b100;
    localparam logic [2:0] F_OR_N  = 3'b101;
    localparam logic [2:0] F_SUB   = 3'b110;
    localparam logic [2:0] F_SLT   = 3'b111;

    // Bit of the function code that inverts B and supplies the adder carry-in.
    localparam int c_INV_B_BIT = 2;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_addsub.sv
// ============================================================================
// Module   : alu_addsub
// Purpose  : Combinational N-bit add/subtract with carry-out and signed overflow.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_addsub #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_inv_b,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf
);

    logic [N-1:0] w_bb;
    logic [N:0]   w_full;

    assign w_bb   = i_inv_b ? ~i_b : i_b;
    assign w_full = {1'b0, i_a} + {1'b0, w_bb} + {{N{1'b0}}, i_inv_b};
    assign o_sum  = w_full[N-1:0];
    assign o_cout = w_full[N];
    // Overflow when both adder inputs share a sign that the result does not.
    assign o_ovf  = (i_a[N-1] == w_bb[N-1]) && (w_full[N-1] != i_a[N-1]);

endmodule : alu_addsub

`default_nettype wire

// File: rtl/alu_reg.sv
// ============================================================================
// Module   : alu_reg
// Purpose  : Registered N-bit ALU (AND/OR/ADD/SUB/SLT, inverted-B logic ops),
//            one cycle latency. Optional macro ALU_ZERO_FLAG_EN adds o_zero.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_reg
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_f,
    output logic [N-1:0] o_y,
    output logic         o_c,
    output logic         o_ovf
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic         o_zero
`endif
);

    logic [N-1:0] w_sum;
    logic         w_cout;
    logic         w_ovf_int;
    logic [N-1:0] w_y;
    logic         w_c;
    logic         w_ovf;

    logic [N-1:0] r_y;
    logic         r_c;
    logic         r_ovf;

    alu_addsub #(.N(N)) u_addsub (
        .i_a     (i_a),
        .i_b     (i_b),
        .i_inv_b (i_f[c_INV_B_BIT]),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_ovf   (w_ovf_int)
    );

    always_comb begin
        w_y   = '0;
        w_c   = 1'b0;
        w_ovf = 1'b0;
        case (i_f)
            F_AND:   w_y = i_a & i_b;
            F_OR:    w_y = i_a | i_b;
            F_AND_N: w_y = i_a & ~i_b;
            F_OR_N:  w_y = i_a | ~i_b;
            F_ADD, F_SUB: begin
                w_y   = w_sum;
                w_c   = w_cout;
                w_ovf = w_ovf_int;
            end
            // Sign of a-b corrected by overflow gives the true signed less-than.
            F_SLT:   w_y = {{(N-1){1'b0}}, w_sum[N-1] ^ w_ovf_int};
            default: w_y = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_y   <= '0;
            r_c   <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_y   <= w_y;
            r_c   <= w_c;
            r_ovf <= w_ovf;
        end
    end

    assign o_y   = r_y;
    assign o_c   = r_c;
    assign o_ovf = r_ovf;

`ifdef ALU_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_zero <= 1'b1;
        end else begin
            r_zero <= (w_y == '0);
        end
    end

    assign o_zero = r_zero;
`endif

endmodule : alu_reg

`default_nettype wire

// File: tb/tb_alu_reg.sv
// ============================================================================
// Module   : tb_alu_reg
// Purpose  : Directed and back-to-back random checks of alu_reg (N=32).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_reg;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   f;
    logic [N-1:0] y;
    logic         c;
    logic         ovf;
`ifdef ALU_ZERO_FLAG_EN
    logic         zero;
`endif

    int errors = 0;
    int checks = 0;

    alu_reg #(.N(N)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_a    (a),
        .i_b    (b),
        .i_f    (f),
        .o_y    (y),
        .o_c    (c),
        .o_ovf  (ovf)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .o_zero (zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference model from signed/unsigned arithmetic semantics: {ovf, c, y}.
    function automatic logic [N+1:0] model(input logic [2:0] fn,
                                           input logic [N-1:0] ma,
                                           input logic [N-1:0] mb);
        logic [N-1:0] ry;
        logic         rc;
        logic         ro;
        longint       sa;
        longint       sb;
        longint       s;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ry = '0;
        rc = 1'b0;
        ro = 1'b0;
        case (fn)
            3'b000: ry = ma & mb;
            3'b001: ry = ma | mb;
            3'b100: ry = ma & ~mb;
            3'b101: ry = ma | ~mb;
            3'b010: begin
                {rc, ry} = {1'b0, ma} + {1'b0, mb};
                s  = sa + sb;
                ro = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                ry = ma - mb;
                rc = (ma >= mb);
                s  = sa - sb;
                ro = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b111: ry = (sa < sb) ? 32'd1 : 32'd0;
            default: ry = '0;
        endcase
        return {ro, rc, ry};
    endfunction

    task automatic check(input string tag, input logic [N-1:0] ey,
                         input logic ec, input logic eo);
        checks++;
        assert (y === ey) else begin
            errors++;
            $error("FAIL %s y: got %h expected %h", tag, y, ey);
        end
        checks++;
        assert (c === ec) else begin
            errors++;
            $error("FAIL %s c: got %b expected %b", tag, c, ec);
        end
        checks++;
        assert (ovf === eo) else begin
            errors++;
            $error("FAIL %s ovf: got %b expected %b", tag, ovf, eo);
        end
`ifdef ALU_ZERO_FLAG_EN
        checks++;
        assert (zero === (ey == '0)) else begin
            errors++;
            $error("FAIL %s zero: got %b expected %b", tag, zero, (ey == '0));
        end
`endif
    endtask

    task automatic op(input string tag, input logic [2:0] fn,
                      input logic [N-1:0] oa, input logic [N-1:0] ob,
                      input logic [N-1:0] ey, input logic ec, input logic eo);
        f = fn;
        a = oa;
        b = ob;
        @(posedge clk);
        #1;
        check(tag, ey, ec, eo);
    endtask

    initial begin
        logic [N+1:0] exp_v;
        logic [2:0]   rf;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        rstn = 1'b0;
        f    = 3'b010;
        a    = 32'hFFFF_FFFF;
        b    = 32'h0000_0001;
        @(posedge clk);
        #1;
        check("reset", 32'h0, 1'b0, 1'b0);
        rstn = 1'b1;

        op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 1'b1, 1'b0);
`ifdef ALU_ZERO_FLAG_EN
        checks++;
        assert (zero === 1'b1) else begin
            errors++;
            $error("FAIL add_wrap_zero: got %b expected 1", zero);
        end
`endif
        op("add_ovf",  3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
        op("sub_neg",  3'b110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op("sub_ovf",  3'b110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        op("slt_ovf",  3'b111, 32'h8000_0000, 32'h1, 32'h1, 1'b0, 1'b0);
        op("slt_eq",   3'b111, 32'd7, 32'd7, 32'h0, 1'b0, 1'b0);
        op("slt_m1",   3'b111, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 1'b0);
        op("slt_gt",   3'b111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        op("and",      3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
        op("or",       3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0);
        op("and_n",    3'b100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_00F0, 1'b0, 1'b0);
        op("or_n",     3'b101, 32'h0000_F0F0, 32'h0000_FF00, 32'hFFFF_F0FF, 1'b0, 1'b0);
        op("unused",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        op("sub_eq",   3'b110, 32'd9, 32'd9, 32'h0, 1'b1, 1'b0);

        // Reset must win over a live operation at the same edge.
        rstn = 1'b0;
        op("reset_prio", 3'b010, 32'h1234_5678, 32'h1, 32'h0, 1'b0, 1'b0);
        rstn = 1'b1;

        for (int i = 0; i < 100; i++) begin
            rf = 3'(i % 8);
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : 32'($urandom);
            if (i % 7 == 0) ra = 32'h8000_0000;
            exp_v = model(rf, ra, rb);
            op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb,
               exp_v[N-1:0], exp_v[N], exp_v[N+1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_reg

`default_nettype wire
